// File: rtl/pin_sync_filter.sv
// Multi-channel pin conditioner: a synchroniser chain, a glitch filter, rise/fall pulses
// and an AVR-style sense-controlled interrupt flag for each channel.
module pin_sync_filter #(
  parameter int               WIDTH     = 8,
  parameter int               STAGES    = 2,
  parameter bit               NEG_FIRST = 1'b1,
  parameter int               FILT_CNT  = 1,
  parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     din,
  input  logic [2*WIDTH-1:0]   sense,
  input  logic [WIDTH-1:0]     flag_clr,
  output logic [WIDTH-1:0]     dsync,
  output logic [WIDTH-1:0]     rise,
  output logic [WIDTH-1:0]     fall,
  output logic [WIDTH-1:0]     irq_flag
);

  localparam int            CW       = $clog2(FILT_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CNT - 1);

  logic [WIDTH-1:0] stage0;
  logic [WIDTH-1:0] sync_q [1:STAGES-1];
  logic [WIDTH-1:0] s;

  // On latch-free fabrics, sampling the pin on the falling edge saves half a cycle of latency.
  generate
    if (NEG_FIRST) begin : g_neg_first
      always_ff @(negedge clk or posedge rst) begin
        if (rst) stage0 <= RST_VAL;
        else     stage0 <= din;
      end
    end else begin : g_pos_first
      always_ff @(posedge clk or posedge rst) begin
        if (rst) stage0 <= RST_VAL;
        else     stage0 <= din;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k < STAGES; k++) sync_q[k] <= RST_VAL;
    end else begin
      sync_q[1] <= stage0;
      for (int k = 2; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[STAGES-1];

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      logic [CW-1:0] cnt;
      logic          level_q;
      logic          rise_q;
      logic          fall_q;
      logic          flag_q;
      logic          ev;

      // The counter tracks how long s has disagreed with the filtered level.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt     <= '0;
          level_q <= RST_VAL[i];
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
        end else if (s[i] == level_q) begin
          cnt    <= '0;
          rise_q <= 1'b0;
          fall_q <= 1'b0;
        end else if (cnt == CNT_LAST) begin
          cnt     <= '0;
          level_q <= s[i];
          rise_q  <= s[i];
          fall_q  <= ~s[i];
        end else begin
          cnt    <= cnt + 1'b1;
          rise_q <= 1'b0;
          fall_q <= 1'b0;
        end
      end

      always_comb begin
        ev = 1'b0;
        case (sense[2*i +: 2])
          2'b01:   ev = rise_q | fall_q;
          2'b10:   ev = fall_q;
          2'b11:   ev = rise_q;
          default: ev = 1'b0;
        endcase
      end

      // A new event wins over a simultaneous clear strobe.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)              flag_q <= 1'b0;
        else if (ev)          flag_q <= 1'b1;
        else if (flag_clr[i]) flag_q <= 1'b0;
      end

      assign dsync[i]    = level_q;
      assign rise[i]     = rise_q;
      assign fall[i]     = fall_q;
      assign irq_flag[i] = (sense[2*i +: 2] == 2'b00) ? ~level_q : flag_q;
    end
  endgenerate

endmodule

// File: tb/tb_pin_sync_filter.sv
// Randomised bench for pin_sync_filter: three configurations share one stimulus stream
// and are compared every cycle against a history-based reference model.
module tb_pin_sync_filter;

  localparam int NI   = 3;
  localparam int NCYC = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic [15:0] sense;
  logic [7:0]  flag_clr;

  logic [7:0] dsync_o [NI];
  logic [7:0] rise_o  [NI];
  logic [7:0] fall_o  [NI];
  logic [7:0] irq_o   [NI];

  always #5 clk = ~clk;

  pin_sync_filter dut_a (
    .clk(clk), .rst(rst), .din(din), .sense(sense), .flag_clr(flag_clr),
    .dsync(dsync_o[0]), .rise(rise_o[0]), .fall(fall_o[0]), .irq_flag(irq_o[0])
  );

  pin_sync_filter #(.WIDTH(8), .STAGES(3), .NEG_FIRST(1'b0), .FILT_CNT(4), .RST_VAL(8'hA5)) dut_b (
    .clk(clk), .rst(rst), .din(din), .sense(sense), .flag_clr(flag_clr),
    .dsync(dsync_o[1]), .rise(rise_o[1]), .fall(fall_o[1]), .irq_flag(irq_o[1])
  );

  pin_sync_filter #(.WIDTH(8), .STAGES(4), .NEG_FIRST(1'b1), .FILT_CNT(8), .RST_VAL(8'h3C)) dut_c (
    .clk(clk), .rst(rst), .din(din), .sense(sense), .flag_clr(flag_clr),
    .dsync(dsync_o[2]), .rise(rise_o[2]), .fall(fall_o[2]), .irq_flag(irq_o[2])
  );

  // Latency from a din value (indexed by the rising edge before which it was stable) to s.
  int         lat  [NI] = '{0, 2, 2};
  int         filt [NI] = '{1, 4, 8};
  logic [7:0] rstv [NI] = '{8'h00, 8'hA5, 8'h3C};

  logic [7:0] dh [0:NCYC+1];
  int         rlast;
  int         n;
  logic [7:0] m_dsync [NI];
  logic [7:0] m_rise  [NI];
  logic [7:0] m_fall  [NI];
  logic [7:0] m_flag  [NI];
  int         checks = 0;
  int         passes = 0;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // s seen after rising edge m: the pin value from lat edges earlier, or the reset level
  // if that value was sampled while reset was active.
  function automatic logic [7:0] sAt(input int inst, input int m);
    int idx;
    idx = m - lat[inst];
    if (idx <= rlast) return rstv[inst];
    return dh[idx];
  endfunction

  function automatic logic [7:0] expIrq(input int inst);
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = (sense[2*i +: 2] == 2'b00) ? ~m_dsync[inst][i] : m_flag[inst][i];
    return r;
  endfunction

  task automatic modelReset();
    for (int j = 0; j < NI; j++) begin
      m_dsync[j] = rstv[j];
      m_rise[j]  = 8'h00;
      m_fall[j]  = 8'h00;
      m_flag[j]  = 8'h00;
    end
  endtask

  // A new level is adopted once s has disagreed with dsync on FILT_CNT consecutive
  // post-reset edges; the flag reacts to the pulses that were visible before this edge.
  task automatic modelEdge(input logic rst_e, input logic [7:0] clr_e, input logic [15:0] sense_e);
    if (rst_e) begin
      rlast = n;
      modelReset();
      return;
    end
    for (int j = 0; j < NI; j++) begin
      for (int i = 0; i < 8; i++) begin
        bit         adopt;
        bit         ev;
        logic [7:0] sv;
        adopt = 1'b1;
        for (int k = 0; k < filt[j]; k++) begin
          sv = sAt(j, n - k - 1);
          if ((n - k) <= rlast || sv[i] == m_dsync[j][i]) adopt = 1'b0;
        end
        case (sense_e[2*i +: 2])
          2'b01:   ev = m_rise[j][i] | m_fall[j][i];
          2'b10:   ev = m_fall[j][i];
          2'b11:   ev = m_rise[j][i];
          default: ev = 1'b0;
        endcase
        m_flag[j][i] = ev | (m_flag[j][i] & ~clr_e[i]);
        if (adopt) begin
          m_dsync[j][i] = ~m_dsync[j][i];
          m_rise[j][i]  = m_dsync[j][i];
          m_fall[j][i]  = ~m_dsync[j][i];
        end else begin
          m_rise[j][i] = 1'b0;
          m_fall[j][i] = 1'b0;
        end
      end
    end
  endtask

  task automatic checkAll(input string when);
    string nm;
    for (int j = 0; j < NI; j++) begin
      nm = $sformatf("%s.inst%0d.cyc%0d", when, j, n);
      checkOutput({nm, ".dsync"}, dsync_o[j], m_dsync[j]);
      checkOutput({nm, ".rise"},  rise_o[j],  m_rise[j]);
      checkOutput({nm, ".fall"},  fall_o[j],  m_fall[j]);
      checkOutput({nm, ".irq"},   irq_o[j],   expIrq(j));
    end
  endtask

  // Alternating busy and quiet phases give both short glitches and long stable runs.
  task automatic applyStimulus(input int cyc);
    for (int i = 0; i < 8; i++) begin
      if (cyc % 200 < 100) begin
        if ($urandom_range(2) == 0) din[i] = ~din[i];
      end else begin
        if ($urandom_range(11) == 0) din[i] = ~din[i];
      end
    end
    flag_clr = 8'($urandom & $urandom);
    if (cyc % 64 == 0) sense = 16'($urandom);
  endtask

  initial begin
    rst      = 1'b1;
    din      = 8'hFF;
    sense    = 16'hE4E4;
    flag_clr = 8'h00;
    rlast    = 0;
    n        = 0;
    modelReset();
    for (int cyc = 1; cyc <= NCYC; cyc++) begin
      @(posedge clk);
      n     = cyc;
      dh[n] = din;
      modelEdge(rst, flag_clr, sense);
      #1;
      checkAll("edge");
      if (cyc == 3) rst = 1'b0;
      if (cyc > 12) applyStimulus(cyc);
      if (cyc % 500 == 250) begin
        rst = 1'b1;
        modelReset();
        #1;
        checkAll("async_rst");
      end else if (cyc % 500 == 252) begin
        rst = 1'b0;
      end
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
